// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b, one bit per clock.
// A borrow flop chains the bit cells; start/busy/done handshake.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  launch request, honoured when not busy
//   a, b   minuend/subtrahend, captured on accepted start
//   busy   high while bits are being processed
//   done   one-cycle pulse, diff/borrow valid
//   diff   (a - b) mod 2^WIDTH, held until next completion
//   borrow final borrow out (a < b unsigned), held with diff
// Build option:
//   SERIAL_SUB_SAT_EN  clamp diff to 0 when the final borrow is 1

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;

  logic             bit_d;
  logic             bo_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_d;
  logic             last;

  // One subtractor bit cell fed by the LSBs and the borrow flop.
  always_comb begin
    bit_d = ra_q[0] ^ rb_q[0] ^ br_q;
    bo_d  = (~ra_q[0] & rb_q[0])
          | (~(ra_q[0] ^ rb_q[0]) & br_q);
    // Result fills from the top so bit 0 ends at the LSB.
    res_d = {bit_d, res_q[WIDTH-1:1]};
    last  = (cnt_q == LAST);
`ifdef SERIAL_SUB_SAT_EN
    diff_d = bo_d ? '0 : res_d;
`else
    diff_d = res_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            ra_q    <= a;
            rb_q    <= b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          ra_q  <= ra_q >> 1;
          rb_q  <= rb_q >> 1;
          res_q <= res_d;
          br_q  <= bo_d;
          if (last) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= diff_d;
            borrow_q <= bo_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for serial_subtractor.
// Drives and samples on the falling edge; expectations queued at launch.

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0      = 0;

  function automatic logic [W-1:0] sat(logic [W-1:0] d, logic bo);
`ifdef SERIAL_SUB_SAT_EN
    return bo ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(logic [W-1:0] av, logic [W-1:0] bv,
                        logic [W-1:0] ed, logic eb);
    exp_t e;
    e.d  = ed;
    e.bo = eb;
    sb.push_back(e);
    a     = av;
    b     = bv;
    start = 1'b1;
    t0    = cyc;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic wait_done(string tag);
    exp_t e;
    while (done !== 1'b1 && (cyc - t0) < 40) tick();
    if (done !== 1'b1) begin
      check({tag, "_timeout"}, 32'(done), 32'd1);
      return;
    end
    check({tag, "_lat"}, 32'(cyc - t0), 32'(W + 1));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_diff"}, 32'(diff), 32'(e.d));
    check({tag, "_borrow"}, 32'(borrow), 32'(e.bo));
  endtask

  task automatic expect_no_done(string tag, int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W:0]   full;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    tick();

    // 100 - 37: busy in cycles 1..8, done in 9
    launch(8'd100, 8'd37, 8'd63, 1'b0);
    for (int i = 1; i <= W; i++) begin
      check($sformatf("c1_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("c1_done%0d", i), 32'(done), 32'd0);
      tick();
    end
    wait_done("c1");
    tick();
    check("c1_pulse", 32'(done), 32'd0);
    tick();
    check("c1_hold", 32'(diff), 32'd63);

    launch(8'd5, 8'd9, sat(8'hFC, 1'b1), 1'b1);
    wait_done("neg");
    tick();
    launch(8'hAA, 8'hAA, 8'h00, 1'b0);
    wait_done("eq");
    tick();
    launch(8'h00, 8'hFF, sat(8'h01, 1'b1), 1'b1);
    wait_done("zmax");
    tick();
    launch(8'hFF, 8'h00, 8'hFF, 1'b0);
    wait_done("maxz");
    tick();

    // start during RUN is ignored
    launch(8'd50, 8'd20, 8'd30, 1'b0);
    tick();
    tick();
    tick();
    a     = 8'd1;
    b     = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign");
    tick();
    tick();
    check("ign_idle", 32'(busy), 32'd0);

    // reset mid-run aborts without done
    launch(8'd77, 8'd11, 8'd66, 1'b0);
    void'(sb.pop_back());
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_diff", 32'(diff), 32'd0);
    check("ab_borrow", 32'(borrow), 32'd0);
    expect_no_done("ab_nodone", 20);
    launch(8'd200, 8'd1, 8'd199, 1'b0);
    wait_done("after_rst");
    tick();

    // reset wins over start
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd4;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rs_busy", 32'(busy), 32'd0);
    expect_no_done("rs_nodone", 15);

    // back-to-back, start held in the DONE cycle
    launch(8'd10, 8'd3, 8'd7, 1'b0);
    wait_done("bb1");
    launch(8'd3, 8'd10, sat(8'hF9, 1'b1), 1'b1);
    for (int i = 0; i < W; i++) begin
      check($sformatf("bb_hold%0d", i), 32'(diff), 32'd7);
      check($sformatf("bb_busy%0d", i), 32'(busy), 32'd1);
      tick();
    end
    wait_done("bb2");
    tick();

    // a few random operands against an arithmetic reference
    for (int k = 0; k < 6; k++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      full = {1'b0, ra} - {1'b0, rb};
      launch(ra, rb, sat(full[W-1:0], full[W]), full[W]);
      wait_done($sformatf("rnd%0d", k));
      tick();
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
